plca_timer_ctrl: RTL and testbench
==================================

PLCA_TIMER_CTRL -- requirements
Module: plca_timer_ctrl

Interface
REQ-001 The block SHALL have parameter CLK_PERIOD_NS, default 40, meaning the clk period in ns (25 MHz MII clock).
REQ-002 The block SHALL have parameter COMMIT_TIMER_NS, default 28800, meaning the nominal commit_timer duration (inside the 28750-28850 ns window).
REQ-003 The block SHALL have parameter PENDING_TIMER_NS, default 51200, meaning the nominal pending_timer duration (inside the 51150-51250 ns window).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have ports start_commit_timer, start_pending_timer and start_mii_clock_timer, input, 1 bit each: start or restart request, sampled on the clk edge.
REQ-007 The block SHALL have ports commit_timer_done and commit_timer_not_done, output, 1 bit each: commit timer status.
REQ-008 The block SHALL have ports pending_timer_done and pending_timer_not_done, output, 1 bit each: pending timer status.
REQ-009 The block SHALL have ports mii_clock_timer_done and mii_clock_timer_not_done, output, 1 bit each: single-MII-clock timer status.
REQ-010 The block SHALL have ports commit_timer_remaining and pending_timer_remaining, output, 11 bits each, present only under PLCA_TIMER_STATUS_EN: remaining count.

Function
REQ-011 The block SHALL derive the cycle count as N = ceil(duration_ns / CLK_PERIOD_NS); defaults give N_commit = 720 and N_pending = 1280.
REQ-012 The block SHALL hold each of the commit and pending timers in one of three states: IDLE, RUNNING or EXPIRED.
REQ-013 IDLE and EXPIRED SHALL go to RUNNING when start is sampled at edge k; the counter loads N-1 and not_done=1 from edge k.
REQ-014 In RUNNING, the counter SHALL decrement by 1 per clk; at count 0 the next edge (k+N) SHALL go to EXPIRED with done=1 and not_done=0.
REQ-015 EXPIRED SHALL hold done=1 until the next start; done and not_done SHALL never both be 1.
REQ-016 A start while RUNNING SHALL reload N-1 with no done pulse.
REQ-017 A start on the expiry cycle SHALL restart the timer, with done kept 0 and not_done kept 1.
REQ-018 The commit and pending timers SHALL be fully independent; simultaneous starts SHALL have no interaction.
REQ-019 The mii_clock_timer (duration 0) SHALL work as follows: start sampled at edge k gives not_done=1 from edge k, then done=1 and not_done=0 from edge k+1.
REQ-020 The mii_clock_timer done SHALL stay high until the next start; a start held high SHALL give done=0/1 alternating per sample pair, never both outputs high.
REQ-021 The counter SHALL never wrap: it is clamped at 0 in EXPIRED and IDLE.
REQ-022 All outputs SHALL be registered, with no combinational path from the start inputs.

Reset
REQ-023 Asserting reset_n=0 SHALL immediately force every timer to IDLE, all done and not_done outputs to 0, and all counters (and remaining outputs) to 0.
REQ-024 A reset during RUNNING SHALL abort the timer with no done pulse; the first start after deassertion behaves as from IDLE.

Configuration
REQ-025 With macro PLCA_TIMER_STATUS_EN defined, the block SHALL expose commit_timer_remaining and pending_timer_remaining, equal to the live counter (0 when IDLE or EXPIRED).
REQ-026 Without PLCA_TIMER_STATUS_EN, those ports and their logic SHALL be absent, with timer behaviour otherwise identical.

Structure
REQ-027 Shared package plca_timer_pkg SHALL hold: the duration constants (min, max and nominal ns), the default CLK_PERIOD_NS, the ceil-divide count function, the counter width (11), and the timer-state enum (IDLE, RUNNING, EXPIRED).
REQ-028 The block SHALL implement one sub-module, plca_timer_cnt, parameterised by N, instantiated for the commit and pending timers; mii_clock_timer SHALL be inline logic.
REQ-029 A compile-time check SHALL error if an N exceeds 2^11-1 or the resulting time falls outside the min/max window.

Verification
REQ-030 Bench SHALL cover: start_commit_timer pulse at edge 10 -> not_done from 10, done from edge 730, not_done=0 at 730.
REQ-031 Bench SHALL cover: start_pending_timer at 0, re-start at 1000 -> no done before 2280; done at edge 2280.
REQ-032 Bench SHALL cover: start_commit_timer coincident with expiry edge -> done stays 0, new expiry 720 cycles later.
REQ-033 Bench SHALL cover: reset_n low at cycle 400 of a pending run -> outputs 0 asynchronously; no done after release without a new start.
REQ-034 Bench SHALL cover: start_mii_clock_timer pulse at edge 5 -> not_done at 5, done at 6 held until the next start.
REQ-035 Bench SHALL cover, with PLCA_TIMER_STATUS_EN: commit_timer_remaining reads 719 at the start edge and 0 at expiry; without the macro, the ports are absent and elaboration is clean.

Source files
------------

// File: rtl/plca_timer_pkg.sv
// Shared constants, types and helpers for the PLCA timer block.
package plca_timer_pkg;

    localparam int unsigned DEFAULT_CLK_PERIOD_NS = 40;

    localparam int unsigned COMMIT_MIN_NS  = 28750;
    localparam int unsigned COMMIT_NOM_NS  = 28800;
    localparam int unsigned COMMIT_MAX_NS  = 28850;

    localparam int unsigned PENDING_MIN_NS = 51150;
    localparam int unsigned PENDING_NOM_NS = 51200;
    localparam int unsigned PENDING_MAX_NS = 51250;

    localparam int unsigned CNT_W   = 11;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        EXPIRED = 2'd2
    } tmr_state_e;

    // Number of whole clk cycles that cover at least duration_ns.
    function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/plca_timer_cnt.sv
// One PLCA down-counting timer of N clk cycles (IDLE / RUNNING / EXPIRED).
// The live count is exported only when PLCA_TIMER_STATUS_EN is defined.
module plca_timer_cnt
    import plca_timer_pkg::*;
#(
    parameter int unsigned N = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    output logic             done,
    output logic             not_done
`ifdef PLCA_TIMER_STATUS_EN
    ,
    output logic [CNT_W-1:0] count
`endif
);

    if (N < 1 || N > CNT_MAX) begin : g_bad_n
        $error("plca_timer_cnt: N=%0d does not fit the %0d-bit counter", N, CNT_W);
    end

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(N - 1);

    tmr_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             not_done_q, not_done_d;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            not_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            not_done_q <= not_done_d;
        end
    end

    // NOTE: every comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (start) begin
            state_d = RUNNING;
            cnt_d   = RELOAD;
        end else begin
            unique case (state_q)
                RUNNING: begin
                    if (cnt_q == '0) begin
                        state_d = EXPIRED;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: cnt_d = '0;
            endcase
        end
    end

    // Status flags follow the next state so they are registered alongside it.
    always_comb begin
        done_d     = (state_d == EXPIRED);
        not_done_d = (state_d == RUNNING);
    end

    assign done     = done_q;
    assign not_done = not_done_q;
`ifdef PLCA_TIMER_STATUS_EN
    assign count    = cnt_q;
`endif

endmodule

// File: rtl/plca_timer_ctrl.sv
// PLCA commit, pending and single-MII-clock timers.
// Define PLCA_TIMER_STATUS_EN to expose the remaining-count outputs.
module plca_timer_ctrl
    import plca_timer_pkg::*;
#(
    parameter int unsigned CLK_PERIOD_NS    = DEFAULT_CLK_PERIOD_NS,
    parameter int unsigned COMMIT_TIMER_NS  = COMMIT_NOM_NS,
    parameter int unsigned PENDING_TIMER_NS = PENDING_NOM_NS
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_commit_timer,
    input  logic             start_pending_timer,
    input  logic             start_mii_clock_timer,
    output logic             commit_timer_done,
    output logic             commit_timer_not_done,
    output logic             pending_timer_done,
    output logic             pending_timer_not_done,
    output logic             mii_clock_timer_done,
    output logic             mii_clock_timer_not_done
`ifdef PLCA_TIMER_STATUS_EN
    ,
    output logic [CNT_W-1:0] commit_timer_remaining,
    output logic [CNT_W-1:0] pending_timer_remaining
`endif
);

    localparam int unsigned N_COMMIT  = ceil_div(COMMIT_TIMER_NS, CLK_PERIOD_NS);
    localparam int unsigned N_PENDING = ceil_div(PENDING_TIMER_NS, CLK_PERIOD_NS);

    if (N_COMMIT > CNT_MAX || N_COMMIT * CLK_PERIOD_NS < COMMIT_MIN_NS ||
        N_COMMIT * CLK_PERIOD_NS > COMMIT_MAX_NS) begin : g_bad_commit
        $error("plca_timer_ctrl: commit timer of %0d cycles is out of range", N_COMMIT);
    end

    if (N_PENDING > CNT_MAX || N_PENDING * CLK_PERIOD_NS < PENDING_MIN_NS ||
        N_PENDING * CLK_PERIOD_NS > PENDING_MAX_NS) begin : g_bad_pending
        $error("plca_timer_ctrl: pending timer of %0d cycles is out of range", N_PENDING);
    end

    plca_timer_cnt #(.N(N_COMMIT)) u_commit_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start_commit_timer),
        .done     (commit_timer_done),
        .not_done (commit_timer_not_done)
`ifdef PLCA_TIMER_STATUS_EN
        ,
        .count    (commit_timer_remaining)
`endif
    );

    plca_timer_cnt #(.N(N_PENDING)) u_pending_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start_pending_timer),
        .done     (pending_timer_done),
        .not_done (pending_timer_not_done)
`ifdef PLCA_TIMER_STATUS_EN
        ,
        .count    (pending_timer_remaining)
`endif
    );

    // Zero-length timer: a start is only accepted when not already running,
    // so a held start alternates not_done/done on successive edges.
    logic mii_done_q, mii_done_d;
    logic mii_not_done_q, mii_not_done_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mii_done_q     <= 1'b0;
            mii_not_done_q <= 1'b0;
        end else begin
            mii_done_q     <= mii_done_d;
            mii_not_done_q <= mii_not_done_d;
        end
    end

    always_comb begin
        mii_not_done_d = start_mii_clock_timer & ~mii_not_done_q;
        mii_done_d     = mii_not_done_q | (mii_done_q & ~start_mii_clock_timer);
    end

    assign mii_clock_timer_done     = mii_done_q;
    assign mii_clock_timer_not_done = mii_not_done_q;

endmodule

// File: tb/tb_plca_timer_ctrl.sv
// Self-checking bench for plca_timer_ctrl: directed scenarios plus random starts,
// compared against a start-time arithmetic model of the three timers.
module tb_plca_timer_ctrl;

    localparam longint N_C = 720;
    localparam longint N_P = 1280;

    logic        clk;
    logic        reset_n;
    logic        start_commit_timer;
    logic        start_pending_timer;
    logic        start_mii_clock_timer;
    logic        commit_timer_done;
    logic        commit_timer_not_done;
    logic        pending_timer_done;
    logic        pending_timer_not_done;
    logic        mii_clock_timer_done;
    logic        mii_clock_timer_not_done;
`ifdef PLCA_TIMER_STATUS_EN
    logic [10:0] commit_timer_remaining;
    logic [10:0] pending_timer_remaining;
`endif

    plca_timer_ctrl dut (
        .clk                      (clk),
        .reset_n                  (reset_n),
        .start_commit_timer       (start_commit_timer),
        .start_pending_timer      (start_pending_timer),
        .start_mii_clock_timer    (start_mii_clock_timer),
        .commit_timer_done        (commit_timer_done),
        .commit_timer_not_done    (commit_timer_not_done),
        .pending_timer_done       (pending_timer_done),
        .pending_timer_not_done   (pending_timer_not_done),
        .mii_clock_timer_done     (mii_clock_timer_done),
        .mii_clock_timer_not_done (mii_clock_timer_not_done)
`ifdef PLCA_TIMER_STATUS_EN
        ,
        .commit_timer_remaining   (commit_timer_remaining),
        .pending_timer_remaining  (pending_timer_remaining)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #20 clk = ~clk;
    end

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Reference model: each timer is described by whether it has been started
    // since reset and at which edge its most recent accepted start happened.
    longint edge_n = 0;
    bit     c_act = 0, p_act = 0, m_act = 0;
    longint c_start = 0, p_start = 0, m_acc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s @edge %0d: got %0d expected %0d", tag, edge_n, obs, exp_v);
        end
    endtask

    task automatic check_all();
        bit     c_nd, c_d, p_nd, p_d, m_nd, m_d;
        longint c_rem, p_rem;
        c_nd  = c_act && (edge_n - c_start < N_C);
        c_d   = c_act && !c_nd;
        p_nd  = p_act && (edge_n - p_start < N_P);
        p_d   = p_act && !p_nd;
        m_nd  = m_act && (m_acc == edge_n);
        m_d   = m_act && (m_acc < edge_n);
        c_rem = c_nd ? (N_C - 1 - (edge_n - c_start)) : 0;
        p_rem = p_nd ? (N_P - 1 - (edge_n - p_start)) : 0;
        check("commit_done",      32'(commit_timer_done),        32'(c_d));
        check("commit_not_done",  32'(commit_timer_not_done),    32'(c_nd));
        check("pending_done",     32'(pending_timer_done),       32'(p_d));
        check("pending_not_done", 32'(pending_timer_not_done),   32'(p_nd));
        check("mii_done",         32'(mii_clock_timer_done),     32'(m_d));
        check("mii_not_done",     32'(mii_clock_timer_not_done), 32'(m_nd));
`ifdef PLCA_TIMER_STATUS_EN
        check("commit_remaining",  32'(commit_timer_remaining),  32'(c_rem));
        check("pending_remaining", 32'(pending_timer_remaining), 32'(p_rem));
`else
        if (c_rem < 0 || p_rem < 0) $display("model remaining negative");
`endif
    endtask

    // Drive one cycle: inputs applied at the falling edge, sampled at the rising
    // edge, outputs compared at the next falling edge.
    task automatic run_cycle(input bit sc, input bit sp, input bit sm);
        start_commit_timer    = sc;
        start_pending_timer   = sp;
        start_mii_clock_timer = sm;
        @(posedge clk);
        edge_n++;
        if (sc) begin c_act = 1; c_start = edge_n; end
        if (sp) begin p_act = 1; p_start = edge_n; end
        if (sm && !(m_act && m_acc == edge_n - 1)) begin m_act = 1; m_acc = edge_n; end
        @(negedge clk);
        check_all();
    endtask

    longint s0, s1, rise;

    initial begin
        reset_n               = 1'b0;
        start_commit_timer    = 1'b0;
        start_pending_timer   = 1'b0;
        start_mii_clock_timer = 1'b0;
        repeat (3) @(negedge clk);
        check_all();
        reset_n = 1'b1;

        // Commit pulse at edge 10: not_done from 10, done from 730.
        repeat (9) run_cycle(0, 0, 0);
        run_cycle(1, 0, 0);
        s0 = edge_n;
        check("commit_start_edge", 32'(s0), 32'd10);
        rise = -1;
        for (int i = 0; i < 800; i++) begin
            run_cycle(0, 0, 0);
            if (rise < 0 && commit_timer_done) rise = edge_n;
        end
        check("commit_latency", 32'(rise - s0), 32'd720);

        // Pending start then restart 1000 edges later: expiry 2280 after the first.
        run_cycle(0, 1, 0);
        s0 = edge_n;
        repeat (999) run_cycle(0, 0, 0);
        run_cycle(0, 1, 0);
        rise = -1;
        for (int i = 0; i < 1400; i++) begin
            run_cycle(0, 0, 0);
            if (rise < 0 && pending_timer_done) rise = edge_n;
        end
        check("pending_restart_latency", 32'(rise - s0), 32'd2280);

        // Commit restart landing exactly on the expiry edge.
        run_cycle(1, 0, 0);
        repeat (719) run_cycle(0, 0, 0);
        run_cycle(1, 0, 0);
        s1 = edge_n;
        check("commit_coincident_done", 32'(commit_timer_done), 32'd0);
        check("commit_coincident_not_done", 32'(commit_timer_not_done), 32'd1);
        rise = -1;
        for (int i = 0; i < 760; i++) begin
            run_cycle(0, 0, 0);
            if (rise < 0 && commit_timer_done) rise = edge_n;
        end
        check("commit_coincident_latency", 32'(rise - s1), 32'd720);

        // Asynchronous reset 400 cycles into a pending run.
        run_cycle(0, 1, 0);
        repeat (399) run_cycle(0, 0, 0);
        #5 reset_n = 1'b0;
        #1;
        c_act = 0; p_act = 0; m_act = 0;
        check("async_reset_pending_not_done", 32'(pending_timer_not_done), 32'd0);
        check_all();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (1400) run_cycle(0, 0, 0);

        // Single-MII-clock timer: pulse, hold, then a held start.
        repeat (4) run_cycle(0, 0, 0);
        run_cycle(0, 0, 1);
        repeat (4) run_cycle(0, 0, 0);
        check("mii_done_held", 32'(mii_clock_timer_done), 32'd1);
        run_cycle(0, 0, 1);
        repeat (6) run_cycle(0, 0, 1);
        run_cycle(0, 0, 0);

        // Random traffic, with some commit starts aimed at the expiry edge.
        for (int i = 0; i < 4000; i++) begin
            bit sc, sp, sm;
            sc = ($urandom_range(0, 499) == 0);
            if (c_act && (edge_n + 1 - c_start == N_C) && $urandom_range(0, 1) == 1) sc = 1;
            sp = ($urandom_range(0, 899) == 0);
            sm = ($urandom_range(0, 5) == 0);
            run_cycle(sc, sp, sm);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
